bpred_ctrl: RTL and testbench

Branch-prediction controller for the fetch stage. It watches the current fetch PC and drives the PC register's prediction inputs: predicted jump and predicted target. It records each outstanding prediction and, when EX resolves the branch, raises the recovery pulses (predicted-taken-but-not-taken, taken-but-predicted-not-taken). It also trains a direct-mapped BTB with 2-bit saturating counters.

---
 rtl/bpred_pkg.sv | 40 ++++
 rtl/bpred_btb.sv | 60 ++++++
 rtl/bpred_ctrl.sv | 156 +++++++++++++++
 tb/tb_bpred_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpred_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor.
package bpred_pkg;

  // Widest tag a table of at least two entries can need (PC[31:3]).
  localparam int unsigned MaxTagW = 29;

  typedef enum logic [1:0] {
    CtrSnt = 2'd0,
    CtrWnt = 2'd1,
    CtrWt  = 2'd2,
    CtrSt  = 2'd3
  } ctr_e;

  typedef enum logic [1:0] {
    BpIdle  = 2'd0,
    BpPend  = 2'd1,
    BpRecov = 2'd2
  } bp_state_e;

  // Tag is stored zero-extended to MaxTagW so the struct does not depend on table size.
  typedef struct packed {
    logic               valid;
    logic [MaxTagW-1:0] tag;
    logic [29:0]        target;
    ctr_e               ctr;
  } btb_entry_t;

  // Two-bit saturating counter step.
  function automatic ctr_e sat_update(ctr_e ctr, logic taken);
    ctr_e res;
    res = ctr;
    if (taken) begin
      if (ctr != CtrSt) res = ctr_e'(ctr + 2'd1);
    end else begin
      if (ctr != CtrSnt) res = ctr_e'(ctr - 2'd1);
    end
    return res;
  endfunction

endpackage

// File: rtl/bpred_btb.sv
// Direct-mapped BTB storage: one combinational read port for fetch lookup and one
// read-modify-write training port committed at the clock edge.
module bpred_btb
  import bpred_pkg::*;
#(
  parameter int unsigned Entries = 16,
  parameter int unsigned IdxW    = $clog2(Entries)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IdxW-1:0]    rd_idx_i,
  output btb_entry_t         rd_entry_o,
  input  logic               upd_valid_i,
  input  logic [IdxW-1:0]    upd_idx_i,
  input  logic [MaxTagW-1:0] upd_tag_i,
  input  logic               upd_taken_i,
  input  logic [29:0]        upd_target_i
);

  btb_entry_t mem_q [Entries];
  btb_entry_t upd_old;
  btb_entry_t upd_new;
  logic       upd_hit;
  logic       upd_we;

  // Fetch lookup sees the stored contents, so a same-cycle write is not visible yet.
  always_comb begin
    rd_entry_o = mem_q[rd_idx_i];
  end

  // Training: bump the counter on a hit, allocate at weakly-taken on a taken miss.
  always_comb begin
    upd_old = mem_q[upd_idx_i];
    upd_hit = upd_old.valid && (upd_old.tag == upd_tag_i);
    upd_new = upd_old;
    upd_we  = 1'b0;
    if (upd_valid_i) begin
      if (upd_hit) begin
        upd_we      = 1'b1;
        upd_new.ctr = sat_update(upd_old.ctr, upd_taken_i);
        if (upd_taken_i) upd_new.target = upd_target_i;
      end else if (upd_taken_i) begin
        upd_we  = 1'b1;
        upd_new = '{valid: 1'b1, tag: upd_tag_i, target: upd_target_i, ctr: CtrWt};
      end
    end
  end

  // Storage with synchronous clear to invalid / weakly-not-taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(Entries); i++) begin
        mem_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CtrWnt};
      end
    end else if (upd_we) begin
      mem_q[upd_idx_i] <= upd_new;
    end
  end

endmodule

// File: rtl/bpred_ctrl.sv
// Branch-prediction controller: BTB lookup for the fetch PC, single outstanding
// prediction tracking and registered recovery pulses.
// Define BPRED_EN to build the predictor; without it all outputs are tied to 0.
module bpred_ctrl
  import bpred_pkg::*;
#(
  parameter int unsigned BTB_ENTRIES = 16,
  parameter int unsigned TAG_W       = 30 - $clog2(BTB_ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_fetch_pc,
  input  logic        i_fetch_hold,
  input  logic        i_flush,
  input  logic        i_res_valid,
  input  logic [31:0] i_res_pc,
  input  logic        i_res_taken,
  input  logic [31:0] i_res_target,
  output logic        o_pred_jump,
  output logic [31:0] o_pred_pc,
  output logic        o_nt_pt,
  output logic        o_t_pnt
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);

`ifdef BPRED_EN

  localparam logic [1:0] StIdle  = BpIdle;
  localparam logic [1:0] StPend  = BpPend;
  localparam logic [1:0] StRecov = BpRecov;

  logic [1:0]         state_q, state_d;
  logic [31:0]        pend_pc_q, pend_pc_d;
  logic [29:0]        pend_target_q, pend_target_d;
  logic               nt_pt_q, nt_pt_d;
  logic               t_pnt_q, t_pnt_d;

  logic [IDX_W-1:0]   fetch_idx;
  logic [TAG_W-1:0]   fetch_tag;
  logic [IDX_W-1:0]   res_idx;
  logic [TAG_W-1:0]   res_tag;
  btb_entry_t         fetch_entry;
  logic               pred_taken;
  logic               pred_jump;
  logic               res_match;
  logic               unused_bits;

  assign fetch_idx   = i_fetch_pc[IDX_W+1:2];
  assign fetch_tag   = i_fetch_pc[31:32-TAG_W];
  assign res_idx     = i_res_pc[IDX_W+1:2];
  assign res_tag     = i_res_pc[31:32-TAG_W];
  assign unused_bits = ^{i_fetch_pc[1:0], i_res_target[1:0]};

  bpred_btb #(
    .Entries (BTB_ENTRIES),
    .IdxW    (IDX_W)
  ) u_btb (
    .clk          (clk),
    .rst          (rst),
    .rd_idx_i     (fetch_idx),
    .rd_entry_o   (fetch_entry),
    .upd_valid_i  (i_res_valid),
    .upd_idx_i    (res_idx),
    .upd_tag_i    (MaxTagW'(res_tag)),
    .upd_taken_i  (i_res_taken),
    .upd_target_i (i_res_target[31:2])
  );

  // Same-cycle prediction; suppressed while reset is held so no stale redirect escapes.
  always_comb begin
    pred_taken  = fetch_entry.valid && (fetch_entry.tag == MaxTagW'(fetch_tag)) &&
                  (fetch_entry.ctr >= CtrWt);
    pred_jump   = !rst && (state_q == StIdle) && pred_taken && !i_fetch_hold && !i_flush;
    o_pred_jump = pred_jump;
    o_pred_pc   = pred_jump ? {fetch_entry.target, 2'b00} : 32'h0;
    o_nt_pt     = nt_pt_q;
    o_t_pnt     = t_pnt_q;
  end

  // Next-state, pending capture and recovery pulse decisions.
  always_comb begin
    state_d       = state_q;
    pend_pc_d     = pend_pc_q;
    pend_target_d = pend_target_q;
    nt_pt_d       = 1'b0;
    t_pnt_d       = 1'b0;
    res_match     = i_res_valid && (state_q == StPend) && (i_res_pc == pend_pc_q);

    case (state_q)
      StIdle: begin
        if (pred_jump) begin
          state_d       = StPend;
          pend_pc_d     = i_fetch_pc;
          pend_target_d = fetch_entry.target;
        end
      end
      StPend: begin
        if (res_match) begin
          if (!i_res_taken) begin
            nt_pt_d = 1'b1;
            state_d = StRecov;
          end else if (i_res_target[31:2] != pend_target_q) begin
            t_pnt_d = 1'b1;
            state_d = StRecov;
          end else begin
            state_d = StIdle;
          end
        end else if (i_flush) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Any taken resolve without a matching prediction was predicted not taken.
    if (i_res_valid && !res_match && i_res_taken) t_pnt_d = 1'b1;
  end

  // State, pending prediction and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      pend_pc_q     <= 32'h0;
      pend_target_q <= 30'h0;
      nt_pt_q       <= 1'b0;
      t_pnt_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_pc_q     <= pend_pc_d;
      pend_target_q <= pend_target_d;
      nt_pt_q       <= nt_pt_d;
      t_pnt_q       <= t_pnt_d;
    end
  end

`else

  logic                   unused_inputs;
  logic [TAG_W+IDX_W-1:0] unused_cfg;

  assign unused_inputs = ^{clk, rst, i_fetch_pc, i_fetch_hold, i_flush, i_res_valid,
                           i_res_pc, i_res_taken, i_res_target};
  assign unused_cfg    = '0;

  // Predictor absent: branches resolve only through the normal jump/branch select.
  always_comb begin
    o_pred_jump = 1'b0;
    o_pred_pc   = 32'h0;
    o_nt_pt     = 1'b0;
    o_t_pnt     = 1'b0;
  end

`endif

endmodule

// File: tb/tb_bpred_ctrl.sv
// Self-checking bench for bpred_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the predictor.
module tb_bpred_ctrl;

`ifdef BPRED_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] fetch_pc = 32'h0;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic        res_valid = 1'b0;
  logic [31:0] res_pc = 32'h0;
  logic        res_taken = 1'b0;
  logic [31:0] res_target = 32'h0;
  logic        pred_jump;
  logic [31:0] pred_pc;
  logic        nt_pt;
  logic        t_pnt;

  bpred_ctrl #(
    .BTB_ENTRIES (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_fetch_pc   (fetch_pc),
    .i_fetch_hold (hold),
    .i_flush      (flush),
    .i_res_valid  (res_valid),
    .i_res_pc     (res_pc),
    .i_res_taken  (res_taken),
    .i_res_target (res_target),
    .o_pred_jump  (pred_jump),
    .o_pred_pc    (pred_pc),
    .o_nt_pt      (nt_pt),
    .o_t_pnt      (t_pnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  // Model: 16-entry table (index PC[5:2], tag PC[31:6]), state 0=idle 1=pend 2=recov.
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  int          m_state = 0;
  logic [31:0] m_pend_pc = 32'h0;
  logic [31:0] m_pend_tgt = 32'h0;
  bit          m_nt = 1'b0;
  bit          m_tp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_predicts(input logic [31:0] pc, output logic [31:0] tgt);
    int idx;
    idx = int'(pc[5:2]);
    tgt = m_tgt[idx];
    return m_valid[idx] && (m_tag[idx] == (pc >> 6)) && (m_ctr[idx] >= 2);
  endfunction

  function automatic bit m_jump(output logic [31:0] tgt);
    bit p;
    p = m_predicts(fetch_pc, tgt);
    return !rst && (m_state == 0) && p && !hold && !flush;
  endfunction

  task automatic model_step();
    bit          pj;
    bit          nt;
    bit          tp;
    bit          match;
    logic [31:0] ptgt;
    int          idx;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 1'b0;
        m_tag[i]   = 32'h0;
        m_tgt[i]   = 32'h0;
        m_ctr[i]   = 1;
      end
      m_state = 0; m_pend_pc = 32'h0; m_pend_tgt = 32'h0; m_nt = 1'b0; m_tp = 1'b0;
      return;
    end
    pj    = m_jump(ptgt);
    nt    = 1'b0;
    tp    = 1'b0;
    match = res_valid && (m_state == 1) && (res_pc == m_pend_pc);
    if (match) begin
      if (!res_taken) begin
        nt = 1'b1; m_state = 2;
      end else if (res_target[31:2] != m_pend_tgt[31:2]) begin
        tp = 1'b1; m_state = 2;
      end else begin
        m_state = 0;
      end
    end else begin
      if (res_valid && res_taken) tp = 1'b1;
      if (m_state == 2) m_state = 0;
      else if (m_state == 1 && flush) m_state = 0;
      else if (m_state == 0 && pj) begin
        m_state = 1; m_pend_pc = fetch_pc; m_pend_tgt = ptgt;
      end
    end
    if (res_valid) begin
      idx = int'(res_pc[5:2]);
      if (m_valid[idx] && m_tag[idx] == (res_pc >> 6)) begin
        if (res_taken) begin
          m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
          m_tgt[idx] = {res_target[31:2], 2'b00};
        end else begin
          m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
        end
      end else if (res_taken) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = res_pc >> 6;
        m_tgt[idx]   = {res_target[31:2], 2'b00};
        m_ctr[idx]   = 2;
      end
    end
    m_nt = nt;
    m_tp = tp;
  endtask

  // Compare every cycle on the falling edge, well away from the sampling edge.
  always @(negedge clk) begin
    logic [31:0] etgt;
    bit          ej;
    if (started) begin
      ej = EN && m_jump(etgt);
      check("pred_jump", {31'h0, pred_jump}, {31'h0, ej});
      check("pred_pc", pred_pc, ej ? etgt : 32'h0);
      check("nt_pt", {31'h0, nt_pt}, {31'h0, EN && m_nt});
      check("t_pnt", {31'h0, t_pnt}, {31'h0, EN && m_tp});
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
    res_valid = 1'b1; res_pc = pc; res_taken = taken; res_target = tgt;
    step();
    res_valid = 1'b0;
  endtask

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(5))
      0: return 32'h40;
      1: return 32'h80;
      2: return 32'hC0;
      3: return 32'h44;
      4: return 32'h1040;
      default: return {$urandom_range(255), 2'b00};
    endcase
  endfunction

  function automatic logic [31:0] pick_tgt();
    case ($urandom_range(3))
      0: return 32'h100;
      1: return 32'h200;
      2: return 32'h300;
      default: return {$urandom, 2'b00};
    endcase
  endfunction

  initial begin
    step();
    started = 1'b1;
    step();
    rst = 1'b0;
    step();
    #1;
    check("reset_jump", {31'h0, pred_jump}, 32'h0);
    check("reset_pc", pred_pc, 32'h0);
    check("reset_nt_pt", {31'h0, nt_pt}, 32'h0);
    check("reset_t_pnt", {31'h0, t_pnt}, 32'h0);

    // Cold start: taken resolve allocates at weakly-taken and pulses t_pnt.
    resolve(32'h40, 1'b1, 32'h100);
    #1;
    check("cold_t_pnt", {31'h0, t_pnt}, {31'h0, EN});
    check("cold_nt_pt", {31'h0, nt_pt}, 32'h0);
    check("model_alloc_valid", {31'h0, m_valid[0]}, 32'h1);
    check("model_alloc_ctr", m_ctr[0], 32'd2);
    step();
    #1;
    check("cold_t_pnt_one_cycle", {31'h0, t_pnt}, 32'h0);
    fetch_pc = 32'h40;
    #1;
    check("hit_jump", {31'h0, pred_jump}, {31'h0, EN});
    check("hit_pc", pred_pc, EN ? 32'h100 : 32'h0);
    step();
    fetch_pc = 32'h0;

    // Predicted taken, resolved not taken.
    resolve(32'h40, 1'b0, 32'h0);
    #1;
    check("nt_pt_pulse", {31'h0, nt_pt}, {31'h0, EN});
    check("nt_pt_no_t_pnt", {31'h0, t_pnt}, 32'h0);
    check("model_ctr_wnt", m_ctr[0], 32'd1);
    step();
    #1;
    check("nt_pt_one_cycle", {31'h0, nt_pt}, 32'h0);
    fetch_pc = 32'h40;
    #1;
    check("wnt_no_jump", {31'h0, pred_jump}, 32'h0);
    fetch_pc = 32'h0;

    // Train to strongly taken, then retarget.
    resolve(32'h40, 1'b1, 32'h100);
    resolve(32'h40, 1'b1, 32'h100);
    resolve(32'h40, 1'b1, 32'h200);
    #1;
    check("retarget_t_pnt", {31'h0, t_pnt}, {31'h0, EN});
    check("model_ctr_st", m_ctr[0], 32'd3);
    check("model_tgt_200", m_tgt[0], 32'h200);
    step();

    // Hold suppresses the prediction; releasing it restores it.
    fetch_pc = 32'h40;
    hold = 1'b1;
    #1;
    check("hold_no_jump", {31'h0, pred_jump}, 32'h0);
    step();
    #1;
    check("hold_still_idle", {31'h0, pred_jump}, 32'h0);
    hold = 1'b0;
    #1;
    check("release_jump", {31'h0, pred_jump}, {31'h0, EN});
    check("release_pc", pred_pc, EN ? 32'h200 : 32'h0);
    step();
    fetch_pc = 32'h0;
    resolve(32'h40, 1'b1, 32'h200);
    #1;
    check("correct_no_t_pnt", {31'h0, t_pnt}, 32'h0);
    check("correct_no_nt_pt", {31'h0, nt_pt}, 32'h0);
    step();

    // Aliasing on index 0 with a different tag.
    fetch_pc = 32'h80;
    #1;
    check("alias_miss", {31'h0, pred_jump}, 32'h0);
    fetch_pc = 32'h0;
    resolve(32'h80, 1'b1, 32'h300);
    #1;
    check("alias_t_pnt", {31'h0, t_pnt}, {31'h0, EN});
    check("model_alias_tag", m_tag[0], 32'h2);
    step();
    fetch_pc = 32'h80;
    #1;
    check("alias_jump", {31'h0, pred_jump}, {31'h0, EN});
    check("alias_pc", pred_pc, EN ? 32'h300 : 32'h0);
    fetch_pc = 32'h40;
    #1;
    check("evicted_no_jump", {31'h0, pred_jump}, 32'h0);

    // Reset while a prediction is outstanding.
    fetch_pc = 32'h80;
    step();
    fetch_pc = 32'h0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    resolve(32'h80, 1'b0, 32'h0);
    #1;
    check("rst_no_nt_pt", {31'h0, nt_pt}, 32'h0);
    fetch_pc = 32'h80;
    #1;
    check("rst_table_clear", {31'h0, pred_jump}, 32'h0);
    check("model_rst_invalid", {31'h0, m_valid[0]}, 32'h0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      fetch_pc   = pick_pc();
      hold       = ($urandom_range(3) == 0);
      flush      = ($urandom_range(9) == 0);
      res_valid  = ($urandom_range(2) == 0);
      res_pc     = ($urandom_range(1) == 1 && m_state == 1) ? m_pend_pc : pick_pc();
      res_taken  = $urandom_range(1) == 1;
      res_target = ($urandom_range(1) == 1) ? m_pend_tgt : pick_tgt();
      rst        = ($urandom_range(149) == 0);
      step();
    end
    rst = 1'b0; res_valid = 1'b0; hold = 1'b0; flush = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
